dw_fifo_pop_stream: RTL and testbench
=====================================

# dw_fifo_pop_stream

Destination-side drain stage for the dual-clock DesignWare FIFO (DW_fifo_2c_df), running entirely in the clk_d domain. It issues pops against the FIFO's show-ahead head word (data_d, empty_d) and converts them into a registered valid/ready stream through a 2-entry skid buffer, sustaining one word per cycle. It also honours the FIFO's destination-side clear handshake by flushing its buffer and suppressing pops for the duration of a clear.

## Interface
- WIDTH, 8, data word width; must equal the FIFO `width`.
- CNT_W, 8, stall counter width (used only with FIFO_POP_STALL_CNT_EN).

Ports:
- clk_d  in  1  destination-domain clock; same clock as the FIFO clk_d.
- rst_d  in  1  reset, synchronous, active-high.
- fifo_empty_d  in  1  FIFO empty_d.
- fifo_data_d  in  WIDTH  FIFO data_d; head word, valid when fifo_empty_d=0.
- fifo_clr_in_prog_d  in  1  FIFO clr_in_prog_d.
- fifo_pop_d_n  out  1  to FIFO pop_d_n, active-low.
- m_valid  out  1  output stream valid.
- m_data  out  WIDTH  output stream data.
- m_ready  in  1  output stream ready.
- buf_cnt  out  2  skid buffer occupancy, 0..2.
- flush_done  out  1  one-cycle pulse when a clear completes.
- stall_cnt  out  CNT_W  saturating count of cycles with m_valid=1 and m_ready=0.

## Operation
- Buffer: 2 entries, 1-bit write and read pointers, and occupancy buf_cnt.
- Pop qualifier: pop = !fifo_empty_d && !fifo_clr_in_prog_d && (buf_cnt != 2). fifo_pop_d_n = !pop, driven combinationally.
  - This path has no combinational dependence on m_ready.
- Capture: on a clk_d edge with pop=1, fifo_data_d is written into entry[wr_ptr] and wr_ptr toggles.
- Output: m_valid = (buf_cnt != 0) && !fifo_clr_in_prog_d. m_data = entry[rd_ptr].
- Transfer: transfer = m_valid && m_ready. On a transfer edge, rd_ptr toggles.
- Occupancy: buf_cnt_next = buf_cnt + pop - transfer.
  - A simultaneous pop and transfer leaves buf_cnt unchanged, with both pointers advancing.
- Pop and transfer each occur at most once per cycle. Neither pointer ever overruns, because pop requires buf_cnt<2 and transfer requires buf_cnt>0.
- Clear:
  - On any edge where fifo_clr_in_prog_d=1: buf_cnt, wr_ptr and rd_ptr are set to 0, and no pop or transfer occurs.
  - The stall counter is also cleared on that edge.
  - Entry contents are don't-care.
- flush_done: registered. Asserted for exactly one cycle, in the cycle after the first edge at which fifo_clr_in_prog_d is sampled 0 following a sample of 1.
- Reset: on an rst_d edge, all state is set to 0, overriding any concurrent pop, transfer or clear.

## Timing
- Reset values:
  - m_valid=0, buf_cnt=0, flush_done=0, stall_cnt=0.
  - m_data is don't-care; 0 is preferred.
  - fifo_pop_d_n=1 while fifo_empty_d=1. Otherwise fifo_pop_d_n follows the pop equation, since buf_cnt=0 after reset.
- Latency: a word popped at edge N is presented on m_valid/m_data in the cycle after edge N.
- Throughput: with m_ready held at 1 and the FIFO non-empty, one word is popped and one delivered every cycle, and buf_cnt stays at 1.
- Backpressure:
  - If m_ready=0, at most 2 more words are popped; then fifo_pop_d_n is held at 1.
  - When m_ready rises, pops resume on the same cycle if buf_cnt<2. Otherwise they resume on the cycle after the first transfer.
- Empty:
  - fifo_empty_d=1 gives fifo_pop_d_n=1 regardless of buffer state.
  - Buffered words still drain to the output.
- Clear mid-stream: m_valid drops in the same cycle that fifo_clr_in_prog_d rises. Buffered words are discarded and never delivered.
- stall_cnt: increments on each edge with m_valid=1 and m_ready=0, and saturates at 2^CNT_W-1.

## Configuration
- FIFO_POP_STALL_CNT_EN:
  - Defined: the stall counter is implemented as specified.
  - Undefined: no counter logic is built and stall_cnt is tied to 0.
  - The port exists in both builds.

## Structure
- Shared package dw_fifo_pop_pkg holds:
  - the buffer depth constant BUF_DEPTH=2;
  - the occupancy typedef (2 bits);
  - the default CNT_W.
- No sub-module. The skid buffer is inline: two entries plus pointer logic.
- The FIFO instance stays in the parent. This block connects to its empty_d, data_d, clr_in_prog_d and pop_d_n ports.

## Test plan
- Streaming: reset, then push 16 words 0x00..0x0F into the FIFO with m_ready=1.
  - Output is 0x00..0x0F in order on 16 consecutive cycles.
  - buf_cnt=1 throughout.
  - Exactly 16 pops.
- Backpressure: with m_ready=0 and 5 words queued, exactly 2 pops occur, then fifo_pop_d_n=1, buf_cnt=2 and m_data=word0.
  - Raising m_ready delivers words 0..4 in order with no loss or duplication.
- Empty boundary: alternate a single FIFO word with empty gaps.
  - fifo_pop_d_n never asserts while fifo_empty_d=1.
  - m_valid pulses once per word.
- Clear mid-stream: with buf_cnt=2, raise fifo_clr_in_prog_d for 4 cycles.
  - m_valid=0 immediately.
  - No pops during the clear.
  - buf_cnt=0.
  - flush_done pulses exactly once after the fall.
  - The next word delivered is the first word pushed after the clear.
- Reset mid-operation: assert rst_d with buf_cnt=2 and a pop and transfer pending.
  - On the next cycle, m_valid=0, buf_cnt=0 and stall_cnt=0.
- Stall counter: with FIFO_POP_STALL_CNT_EN defined, CNT_W=4, hold m_ready=0 for 20 cycles with a word valid.
  - stall_cnt saturates at 15.
  - A clear returns it to 0.
  - Without the macro, stall_cnt stays at 0.

Source files
------------

// File: rtl/dw_fifo_pop_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dw_fifo_pop_pkg
// Purpose  : Shared constants and types for the DW_fifo_2c_df drain stage:
//            skid buffer depth, occupancy type and default stall counter width.
// Ports    : n/a (package)
// Revision : 1.0 - initial release
// ============================================================================
package dw_fifo_pop_pkg;

  // Skid buffer depth; occupancy spans 0..BUF_DEPTH.
  localparam int BUF_DEPTH = 2;

  // Default width of the optional stall counter.
  localparam int CNT_W_DEFAULT = 8;

  // Occupancy of the skid buffer (0..2).
  typedef logic [1:0] occ_t;

endpackage
`default_nettype wire

// File: rtl/dw_fifo_pop_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : dw_fifo_pop_stream_if
// Purpose  : Bundles the FIFO destination-side head-word signals and the
//            outgoing valid/ready stream of the drain stage.
// Ports    : fifo_empty_d, fifo_data_d, fifo_clr_in_prog_d -> drain stage
//            fifo_pop_d_n (active-low)                     -> FIFO
//            m_valid, m_data                               -> stream sink
//            m_ready                                       -> drain stage
//            modport master : the drain stage
//            modport slave  : FIFO + stream sink side
// Revision : 1.0 - initial release
// ============================================================================
interface dw_fifo_pop_stream_if #(
  parameter int WIDTH = 8
);

  logic             fifo_empty_d;
  logic [WIDTH-1:0] fifo_data_d;
  logic             fifo_clr_in_prog_d;
  logic             fifo_pop_d_n;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;

  modport master (
    input  fifo_empty_d,
    input  fifo_data_d,
    input  fifo_clr_in_prog_d,
    output fifo_pop_d_n,
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    output fifo_empty_d,
    output fifo_data_d,
    output fifo_clr_in_prog_d,
    input  fifo_pop_d_n,
    input  m_valid,
    input  m_data,
    output m_ready
  );

endinterface
`default_nettype wire

// File: rtl/dw_fifo_pop_stream.sv
`default_nettype none
// ============================================================================
// Module   : dw_fifo_pop_stream
// Purpose  : clk_d-domain drain stage for DW_fifo_2c_df. Pops the show-ahead
//            head word into a 2-entry skid buffer and presents it as a
//            registered valid/ready stream at one word per cycle. Flushes the
//            buffer and suppresses pops while the FIFO clear is in progress.
// Ports    : clk_d, rst_d (sync, active-high)
//            bus        : dw_fifo_pop_stream_if.master (FIFO head + stream)
//            buf_cnt    : skid buffer occupancy 0..2
//            flush_done : one-cycle pulse after a clear completes
//            stall_cnt  : saturating count of valid-but-not-ready cycles
// Config   : FIFO_POP_STALL_CNT_EN - build the stall counter; when undefined
//            stall_cnt is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module dw_fifo_pop_stream
  import dw_fifo_pop_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  wire logic               clk_d,
  input  wire logic               rst_d,
  dw_fifo_pop_stream_if.master    bus,
  output occ_t                    buf_cnt,
  output logic                    flush_done,
  output logic [CNT_W-1:0]        stall_cnt
);

  logic [WIDTH-1:0] r_entry [BUF_DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  occ_t             r_buf_cnt;
  logic             r_clr_q;
  logic             r_flush_done;

  logic             w_clr;
  logic             w_pop;
  logic             w_valid;
  logic             w_xfer;

  assign w_clr = bus.fifo_clr_in_prog_d;

  // Pop depends only on FIFO state and local occupancy, never on m_ready,
  // so there is no combinational path from the sink back to the FIFO.
  assign w_pop   = !bus.fifo_empty_d && !w_clr && (r_buf_cnt != occ_t'(BUF_DEPTH));
  // Valid is masked by the clear so buffered words vanish in the same cycle.
  assign w_valid = (r_buf_cnt != '0) && !w_clr;
  assign w_xfer  = w_valid && bus.m_ready;

  assign bus.fifo_pop_d_n = !w_pop;
  assign bus.m_valid      = w_valid;
  assign bus.m_data       = r_entry[r_rd_ptr];
  assign buf_cnt          = r_buf_cnt;
  assign flush_done       = r_flush_done;

  // Skid buffer: entries, pointers and occupancy.
  always_ff @(posedge clk_d) begin
    if (rst_d) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_entry[i] <= '0;
      end
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_buf_cnt <= '0;
    end else if (w_clr) begin
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_buf_cnt <= '0;
    end else begin
      if (w_pop) begin
        r_entry[r_wr_ptr] <= bus.fifo_data_d;
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (w_xfer) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_buf_cnt <= r_buf_cnt + occ_t'(w_pop) - occ_t'(w_xfer);
    end
  end

  // Clear-completion detect: pulse on the first 0 sample after a 1 sample.
  always_ff @(posedge clk_d) begin
    if (rst_d) begin
      r_clr_q      <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_clr_q      <= w_clr;
      r_flush_done <= r_clr_q && !w_clr;
    end
  end

`ifdef FIFO_POP_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk_d) begin
    if (rst_d || w_clr) begin
      r_stall_cnt <= '0;
    end else if (w_valid && !bus.m_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dw_fifo_pop_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_dw_fifo_pop_stream
// Purpose  : Self-checking bench for dw_fifo_pop_stream. A vector table walks
//            the buffer through pop/transfer/clear cases with directly driven
//            FIFO inputs; hand-written sequences then use a small queue model
//            of the FIFO for streaming, backpressure, empty gaps, clear,
//            reset and stall-counter saturation.
// Config   : FIFO_POP_STALL_CNT_EN selects the expected stall_cnt values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dw_fifo_pop_stream;

`ifdef FIFO_POP_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic       clk_d;
  logic       rst_d;
  logic [1:0] buf_cnt;
  logic       flush_done;
  logic [3:0] stall_cnt;

  dw_fifo_pop_stream_if #(.WIDTH(8)) bus ();

  dw_fifo_pop_stream #(.WIDTH(8), .CNT_W(4)) dut (
    .clk_d      (clk_d),
    .rst_d      (rst_d),
    .bus        (bus),
    .buf_cnt    (buf_cnt),
    .flush_done (flush_done),
    .stall_cnt  (stall_cnt)
  );

  initial begin
    clk_d = 1'b0;
    forever #5 clk_d = ~clk_d;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int         checks   = 0;
  int         failures = 0;
  int         pops     = 0;
  int         viol     = 0;
  bit         use_model = 1'b0;
  logic [7:0] q[$];
  logic [7:0] got[$];

  typedef struct {
    logic       empty;
    logic [7:0] data;
    logic       clr;
    logic       ready;
    logic       exp_pop_n;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [1:0] exp_cnt;
    logic       exp_flush;
    logic [3:0] exp_stall;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(logic e, logic [7:0] d, logic c, logic r, logic pn,
                              logic v, logic [7:0] md, logic [1:0] cnt,
                              logic fl, logic [3:0] st);
    vec_t x;
    x.empty = e; x.data = d; x.clr = c; x.ready = r;
    x.exp_pop_n = pn; x.exp_valid = v; x.exp_data = md; x.exp_cnt = cnt;
    x.exp_flush = fl; x.exp_stall = st;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    bus.fifo_empty_d = (q.size() == 0);
    bus.fifo_data_d  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  // One clock: record pop/transfer decisions just before the edge, then
  // advance the FIFO model and let inputs settle.
  task automatic tick();
    bit p;
    p = (bus.fifo_pop_d_n == 1'b0);
    if (p && bus.fifo_empty_d) viol++;
    if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
    @(posedge clk_d);
    #1;
    if (p) begin
      pops++;
      if (use_model && q.size() != 0) void'(q.pop_front());
    end
    if (use_model) drive_fifo();
    #1;
  endtask

  task automatic do_reset();
    q.delete();
    drive_fifo();
    bus.fifo_clr_in_prog_d = 1'b0;
    rst_d = 1'b1;
    tick();
    tick();
    rst_d = 1'b0;
    pops = 0;
    viol = 0;
    got.delete();
  endtask

  initial begin
    int fl;
    int vcount;
    int p0;

    // Pre-edge: inputs, pop_n, valid, data. Post-edge: cnt, flush, stall.
    tbl[0] = mk(1, 8'h11, 0, 0, 1, 0, 8'h00, 2'd0, 0, 4'd0);
    tbl[1] = mk(0, 8'hA1, 0, 0, 0, 0, 8'h00, 2'd1, 0, 4'd0);
    tbl[2] = mk(0, 8'hB2, 0, 0, 0, 1, 8'hA1, 2'd2, 0, 4'd1);
    tbl[3] = mk(0, 8'hC3, 0, 0, 1, 1, 8'hA1, 2'd2, 0, 4'd2);
    tbl[4] = mk(0, 8'hC3, 0, 1, 1, 1, 8'hA1, 2'd1, 0, 4'd2);
    tbl[5] = mk(0, 8'hC3, 0, 1, 0, 1, 8'hB2, 2'd1, 0, 4'd2);
    tbl[6] = mk(1, 8'h00, 0, 0, 1, 1, 8'hC3, 2'd1, 0, 4'd3);
    tbl[7] = mk(0, 8'hD4, 1, 1, 1, 0, 8'h00, 2'd0, 0, 4'd0);
    tbl[8] = mk(0, 8'hD4, 0, 1, 0, 0, 8'h00, 2'd1, 1, 4'd0);
    tbl[9] = mk(1, 8'h00, 0, 1, 1, 1, 8'hD4, 2'd0, 0, 4'd0);

    bus.m_ready = 1'b0;
    use_model   = 1'b1;
    do_reset();

    // Reset state
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_cnt", buf_cnt, 0);
    chk("rst_flush", flush_done, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_pop_n", bus.fifo_pop_d_n, 1);
    chk("rst_mdata", bus.m_data, 0);

    // Vector table with directly driven FIFO inputs
    use_model = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.fifo_empty_d       = tbl[i].empty;
      bus.fifo_data_d        = tbl[i].data;
      bus.fifo_clr_in_prog_d = tbl[i].clr;
      bus.m_ready            = tbl[i].ready;
      #1;
      chk($sformatf("tbl%0d_pop_n", i), bus.fifo_pop_d_n, tbl[i].exp_pop_n);
      chk($sformatf("tbl%0d_valid", i), bus.m_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) chk($sformatf("tbl%0d_data", i), bus.m_data, tbl[i].exp_data);
      tick();
      chk($sformatf("tbl%0d_cnt", i), buf_cnt, tbl[i].exp_cnt);
      chk($sformatf("tbl%0d_flush", i), flush_done, tbl[i].exp_flush);
      chk($sformatf("tbl%0d_stall", i), stall_cnt, STALL_EN ? tbl[i].exp_stall : 4'd0);
    end
    use_model = 1'b1;
    bus.fifo_clr_in_prog_d = 1'b0;

    // Streaming: 16 words at full rate
    bus.m_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) q.push_back(8'(i));
    drive_fifo();
    #1;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("stream%0d_valid", i), bus.m_valid, 1);
      chk($sformatf("stream%0d_data", i), bus.m_data, i);
      chk($sformatf("stream%0d_cnt", i), buf_cnt, 1);
      tick();
    end
    chk("stream_pops", pops, 16);
    chk("stream_xfers", got.size(), 16);

    // Backpressure: only two pops while m_ready is low
    bus.m_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) q.push_back(8'h20 + 8'(i));
    drive_fifo();
    #1;
    repeat (4) tick();
    chk("bp_pops", pops, 2);
    chk("bp_pop_n", bus.fifo_pop_d_n, 1);
    chk("bp_cnt", buf_cnt, 2);
    chk("bp_data", bus.m_data, 8'h20);
    got.delete();
    bus.m_ready = 1'b1;
    #1;
    repeat (10) tick();
    chk("bp_count", got.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_word%0d", i), (got.size() > i) ? got[i] : 8'hFF, 8'h20 + 8'(i));
    end

    // Empty boundary: single words separated by empty gaps
    bus.m_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      q.push_back(8'h30 + 8'(k));
      drive_fifo();
      #1;
      vcount = 0;
      repeat (4) begin
        if (bus.m_valid) vcount++;
        tick();
      end
      chk($sformatf("empty%0d_pulses", k), vcount, 1);
    end
    chk("empty_pop_violations", viol, 0);
    chk("empty_words", got.size(), 4);

    // Clear mid-stream with a full buffer
    bus.m_ready = 1'b0;
    do_reset();
    q.push_back(8'h40); q.push_back(8'h41); q.push_back(8'h42);
    drive_fifo();
    #1;
    tick();
    tick();
    chk("clr_pre_cnt", buf_cnt, 2);
    bus.fifo_clr_in_prog_d = 1'b1;
    q.delete();
    drive_fifo();
    #1;
    chk("clr_valid_now", bus.m_valid, 0);
    p0 = pops;
    fl = 0;
    repeat (4) begin
      tick();
      if (flush_done) fl++;
    end
    chk("clr_pops", pops, p0);
    chk("clr_cnt", buf_cnt, 0);
    bus.fifo_clr_in_prog_d = 1'b0;
    #1;
    repeat (5) begin
      tick();
      if (flush_done) fl++;
    end
    chk("clr_flush_pulses", fl, 1);
    got.delete();
    q.push_back(8'h50);
    drive_fifo();
    bus.m_ready = 1'b1;
    #1;
    repeat (4) tick();
    chk("clr_next_count", got.size(), 1);
    chk("clr_next_word", (got.size() > 0) ? got[0] : 8'hFF, 8'h50);

    // Reset in the middle of operation
    bus.m_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) q.push_back(8'h60 + 8'(i));
    drive_fifo();
    #1;
    tick();
    tick();
    chk("midrst_pre_cnt", buf_cnt, 2);
    bus.m_ready = 1'b1;
    rst_d = 1'b1;
    #1;
    tick();
    rst_d = 1'b0;
    #1;
    chk("midrst_valid", bus.m_valid, 0);
    chk("midrst_cnt", buf_cnt, 0);
    chk("midrst_stall", stall_cnt, 0);

    // Stall counter saturation and clear
    bus.m_ready = 1'b0;
    do_reset();
    q.push_back(8'h70);
    drive_fifo();
    #1;
    repeat (21) tick();
    chk("stall_sat", stall_cnt, STALL_EN ? 4'd15 : 4'd0);
    bus.fifo_clr_in_prog_d = 1'b1;
    q.delete();
    drive_fifo();
    #1;
    tick();
    bus.fifo_clr_in_prog_d = 1'b0;
    #1;
    chk("stall_cleared", stall_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
